alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU (funct-coded, 6-bit control) between two requesters,
//  e.g. the execute stage (port 0) and a branch/compare helper (port 1).

---
 rtl/alu_share_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. A round-robin (or
//   fixed-priority) grant accepts one request at a time in IDLE, the operands
//   and function code are registered onto the ALU inputs, the ALU output is
//   captured one cycle later and held on the shared response bus until the
//   owning port takes it.
// Ports
//   clk, reset                     clock / synchronous active-high reset
//   reqN_valid/op1/op2/ctrl/ready  request side, N = 0,1 (ready is combinational)
//   alu_op1/alu_op2/alu_control    registered drive into the shared ALU
//   alu_result/alu_zero            combinational ALU outputs
//   rspN_valid/rspN_ready          per-port response handshake
//   rsp_result/rsp_zero/rsp_err    shared registered response bus
module alu_share_arbiter #(
   parameter int WIDTH      = 32,
   parameter int CTRL_W     = 6,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [WIDTH-1:0]  req0_op1,
   input  logic [WIDTH-1:0]  req0_op2,
   input  logic [CTRL_W-1:0] req0_ctrl,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [WIDTH-1:0]  req1_op1,
   input  logic [WIDTH-1:0]  req1_op2,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              req1_ready,
   output logic [WIDTH-1:0]  alu_op1,
   output logic [WIDTH-1:0]  alu_op2,
   output logic [CTRL_W-1:0] alu_control,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   input  logic              rsp0_ready,
   input  logic              rsp1_ready,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero,
   output logic              rsp_err
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [CTRL_W-1:0] F_ADD = CTRL_W'(6'b100000);
   localparam logic [CTRL_W-1:0] F_SUB = CTRL_W'(6'b100010);
   localparam logic [CTRL_W-1:0] F_AND = CTRL_W'(6'b100100);
   localparam logic [CTRL_W-1:0] F_OR  = CTRL_W'(6'b100101);
   localparam logic [CTRL_W-1:0] F_XOR = CTRL_W'(6'b100110);
   localparam logic [CTRL_W-1:0] F_NOR = CTRL_W'(6'b100111);
   localparam logic [CTRL_W-1:0] F_SLT = CTRL_W'(6'b101010);

   state_t state, state_nxt;
   logic   prio;    // 0: port 0 wins a tie, 1: port 1 wins a tie
   logic   owner;   // port that owns the operation in flight
   logic   grant0, grant1;

   function automatic logic known_op(input logic [CTRL_W-1:0] c);
      case (c)
         F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT: known_op = 1'b1;
         default:                                        known_op = 1'b0;
      endcase
   endfunction

   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      case (state)
         IDLE: begin
            if (FIXED_PRIO || !prio) begin
               grant0 = req0_valid;
               grant1 = req1_valid & ~req0_valid;
            end else begin
               grant1 = req1_valid;
               grant0 = req0_valid & ~req1_valid;
            end
            if (grant0 || grant1) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grants are only ever raised in IDLE, so ready needs no extra state gating.
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = (state == RESP) && !owner;
   assign rsp1_valid = (state == RESP) &&  owner;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         prio        <= 1'b0;
         owner       <= 1'b0;
         alu_op1     <= '0;
         alu_op2     <= '0;
         alu_control <= '0;
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
         rsp_err     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant0 || grant1) begin
            alu_op1     <= grant1 ? req1_op1  : req0_op1;
            alu_op2     <= grant1 ? req1_op2  : req0_op2;
            alu_control <= grant1 ? req1_ctrl : req0_ctrl;
            owner       <= grant1;
            // Hand the tie-break to whichever port did not just win.
            prio        <= grant0;
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= ~known_op(alu_control);
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter: a round-robin instance and a
//   fixed-priority instance, each fed by a small reference ALU.
module tb_alu_share_arbiter;

   localparam logic [5:0] ADD = 6'b100000;
   localparam logic [5:0] SUB = 6'b100010;
   localparam logic [5:0] OR_ = 6'b100101;
   localparam logic [5:0] SLT = 6'b101010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   function automatic logic [31:0] alu_f(input logic [31:0] a, b, input logic [5:0] c);
      case (c)
         6'b100000: alu_f = a + b;
         6'b100010: alu_f = a - b;
         6'b100100: alu_f = a & b;
         6'b100101: alu_f = a | b;
         6'b100110: alu_f = a ^ b;
         6'b100111: alu_f = ~(a | b);
         6'b101010: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default:   alu_f = 32'd0;
      endcase
   endfunction

   // round-robin instance
   logic        reset = 1'b1;
   logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
   logic [31:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
   logic [5:0]  req0_ctrl = 0, req1_ctrl = 0;
   logic [31:0] alu_op1, alu_op2, alu_result, rsp_result;
   logic [5:0]  alu_control;
   logic        alu_zero, rsp0_valid, rsp1_valid, rsp_zero, rsp_err;
   logic        rsp0_ready = 0, rsp1_ready = 0;

   assign alu_result = alu_f(alu_op1, alu_op2, alu_control);
   assign alu_zero   = (alu_result == 32'd0);

   alu_share_arbiter #(.WIDTH(32), .CTRL_W(6), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_op1(req0_op1), .req0_op2(req0_op2),
      .req0_ctrl(req0_ctrl), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op1(req1_op1), .req1_op2(req1_op2),
      .req1_ctrl(req1_ctrl), .req1_ready(req1_ready),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   // fixed-priority instance
   logic        f_reset = 1'b1;
   logic        f_req0_valid = 0, f_req1_valid = 0, f_req0_ready, f_req1_ready;
   logic [31:0] f_alu_op1, f_alu_op2, f_alu_result, f_rsp_result;
   logic [5:0]  f_alu_control;
   logic        f_alu_zero, f_rsp0_valid, f_rsp1_valid, f_rsp_zero, f_rsp_err;
   logic        f_rsp_ready = 0;

   assign f_alu_result = alu_f(f_alu_op1, f_alu_op2, f_alu_control);
   assign f_alu_zero   = (f_alu_result == 32'd0);

   alu_share_arbiter #(.WIDTH(32), .CTRL_W(6), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .reset(f_reset),
      .req0_valid(f_req0_valid), .req0_op1(32'd5), .req0_op2(32'd3),
      .req0_ctrl(ADD), .req0_ready(f_req0_ready),
      .req1_valid(f_req1_valid), .req1_op1(32'd7), .req1_op2(32'd7),
      .req1_ctrl(SUB), .req1_ready(f_req1_ready),
      .alu_op1(f_alu_op1), .alu_op2(f_alu_op2), .alu_control(f_alu_control),
      .alu_result(f_alu_result), .alu_zero(f_alu_zero),
      .rsp0_valid(f_rsp0_valid), .rsp1_valid(f_rsp1_valid),
      .rsp0_ready(f_rsp_ready), .rsp1_ready(f_rsp_ready),
      .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero), .rsp_err(f_rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
   endtask

   // Wait (bounded) for a response, check it, then take it with a one-cycle ready.
   task automatic wait_rsp(input bit port, input logic [31:0] res, input logic zero,
                           input logic err, input string tag);
      int n = 0;
      while (!(rsp0_valid || rsp1_valid) && n < 8) begin
         tick;
         n++;
      end
      chk({tag, "_valid"},  port ? rsp1_valid : rsp0_valid, 1);
      chk({tag, "_other"},  port ? rsp0_valid : rsp1_valid, 0);
      chk({tag, "_result"}, rsp_result, res);
      chk({tag, "_zero"},   rsp_zero, zero);
      chk({tag, "_err"},    rsp_err, err);
      if (port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      tick;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int prev;
      int n;
      logic g;

      // reset state
      do_reset;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_alu_op1", alu_op1, 0);
      chk("rst_alu_ctrl", alu_control, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_err", rsp_err, 0);

      // 1: single ADD on port 0, latency T -> T+2
      req0_valid = 1; req0_op1 = 5; req0_op2 = 3; req0_ctrl = ADD;
      #1;
      chk("t1_req0_ready", req0_ready, 1);
      chk("t1_req1_ready", req1_ready, 0);
      tick;
      req0_valid = 0;
      chk("t1_exec_rsp0", rsp0_valid, 0);
      chk("t1_alu_op1", alu_op1, 5);
      chk("t1_alu_ctrl", alu_control, ADD);
      tick;
      chk("t1_rsp0_valid", rsp0_valid, 1);
      chk("t1_result", rsp_result, 8);
      chk("t1_zero", rsp_zero, 0);

      // 3: response held 4 cycles, nothing accepted meanwhile
      req1_valid = 1; req1_op1 = 1; req1_op2 = 1; req1_ctrl = ADD;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("t3_req1_ready", req1_ready, 0);
         chk("t3_rsp0_valid", rsp0_valid, 1);
         chk("t3_result", rsp_result, 8);
         tick;
      end
      wait_rsp(0, 32'd8, 0, 0, "t3_rsp0");
      chk("t3_req1_granted", req1_ready, 1);
      tick;
      req1_valid = 0;
      wait_rsp(1, 32'd2, 0, 0, "t3_rsp1");

      // 2: tie after reset -> port 0, then port 1, then port 0 again
      do_reset;
      req0_valid = 1; req0_op1 = 3; req0_op2 = 5; req0_ctrl = SUB;
      req1_valid = 1; req1_op1 = 7; req1_op2 = 7; req1_ctrl = SUB;
      #1;
      chk("t2_tie_req0", req0_ready, 1);
      chk("t2_tie_req1", req1_ready, 0);
      tick;
      req0_valid = 0;
      #1;
      chk("t2_req1_wait", req1_ready, 0);
      wait_rsp(0, 32'hFFFF_FFFE, 0, 0, "t2_p0");
      chk("t2_req1_grant", req1_ready, 1);
      tick;
      req1_valid = 0;
      wait_rsp(1, 32'd0, 1, 0, "t2_p1");
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("t2_tie2_req0", req0_ready, 1);
      chk("t2_tie2_req1", req1_ready, 0);
      tick;
      req0_valid = 0;
      wait_rsp(0, 32'hFFFF_FFFE, 0, 0, "t2_p0b");
      tick;
      req1_valid = 0;
      wait_rsp(1, 32'd0, 1, 0, "t2_p1b");

      // 4: unsupported code and SLT on port 1, OR and ADDU on port 0
      req1_valid = 1; req1_op1 = 9; req1_op2 = 9; req1_ctrl = 6'b000000;
      tick;
      req1_valid = 0;
      wait_rsp(1, 32'd0, 1, 1, "t4_bad");
      req1_valid = 1; req1_op1 = 32'hFFFF_FFFF; req1_op2 = 1; req1_ctrl = SLT;
      tick;
      req1_valid = 0;
      wait_rsp(1, 32'd1, 0, 0, "t4_slt");
      req0_valid = 1; req0_op1 = 32'hF0; req0_op2 = 32'h0F; req0_ctrl = OR_;
      tick;
      req0_valid = 0;
      wait_rsp(0, 32'hFF, 0, 0, "t4_or");
      req0_valid = 1; req0_op1 = 4; req0_op2 = 4; req0_ctrl = 6'b100001;
      tick;
      req0_valid = 0;
      wait_rsp(0, 32'd0, 1, 1, "t4_addu");

      // 5: reset during EXEC discards the op and restores port-0 priority
      req0_valid = 1; req0_op1 = 5; req0_op2 = 3; req0_ctrl = ADD;
      tick;
      req0_valid = 0;
      reset = 1;
      tick;
      reset = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t5_rsp0_valid", rsp0_valid, 0);
         chk("t5_rsp1_valid", rsp1_valid, 0);
         tick;
      end
      chk("t5_alu_op1", alu_op1, 0);
      chk("t5_alu_ctrl", alu_control, 0);
      chk("t5_rsp_err", rsp_err, 0);
      chk("t5_rsp_zero", rsp_zero, 0);
      req0_valid = 1; req1_valid = 1;
      req1_op1 = 7; req1_op2 = 7; req1_ctrl = SUB;
      #1;
      chk("t5_tie_req0", req0_ready, 1);
      chk("t5_tie_req1", req1_ready, 0);
      tick;
      req0_valid = 0;
      wait_rsp(0, 32'd8, 0, 0, "t5_p0");
      tick;
      req1_valid = 0;
      wait_rsp(1, 32'd0, 1, 0, "t5_p1");

      // 6: both ports always valid, grants alternate (round-robin instance)
      do_reset;
      rsp0_ready = 1; rsp1_ready = 1;
      req0_valid = 1; req1_valid = 1;
      #1;
      prev = 1;
      for (int k = 0; k < 20; k++) begin
         n = 0;
         while (!(req0_ready || req1_ready) && n < 8) begin
            tick;
            n++;
         end
         chk("t6_grant_seen", req0_ready | req1_ready, 1);
         chk("t6_both_ready", req0_ready & req1_ready, 0);
         g = req1_ready;
         chk("t6_alternate", g, !prev[0]);
         prev = g;
         tick;
      end
      req0_valid = 0; req1_valid = 0;
      rsp0_ready = 0; rsp1_ready = 0;

      // 6b: fixed-priority instance never grants port 1 under contention
      f_reset = 1;
      tick;
      tick;
      f_reset = 0;
      f_rsp_ready = 1;
      f_req0_valid = 1; f_req1_valid = 1;
      #1;
      for (int k = 0; k < 20; k++) begin
         n = 0;
         while (!(f_req0_ready || f_req1_ready) && n < 8) begin
            tick;
            n++;
         end
         chk("t6f_grant0", f_req0_ready, 1);
         chk("t6f_grant1", f_req1_ready, 0);
         tick;
      end
      chk("t6f_result", f_rsp_result, 8);
      chk("t6f_err", f_rsp_err, 0);
      f_req0_valid = 0; f_req1_valid = 0;
      tick;
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
